// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers column/row position and lock status from HSync/VSync; o_Frame_Count exists only with VGA_SYNC_DECODER_FRAME_COUNT_EN
module vga_sync_decoder #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_HSync,
  input  logic        i_VSync,
  output logic [9:0]  o_Col_Count,
  output logic [9:0]  o_Row_Count,
  output logic        o_Active,
  output logic        o_Frame_Start,
  output logic        o_Locked,
`ifdef VGA_SYNC_DECODER_FRAME_COUNT_EN
  output logic        o_Error,
  output logic [15:0] o_Frame_Count
`else
  output logic        o_Error
`endif
);
  localparam int CW = $clog2(LOCK_FRAMES + 2);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t state_q, state_d;
  logic hs_q, vs_q;
  logic [9:0] col_q, row_q, col_d, row_d, pc, pr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hs_rise, hs_fall, vs_rise, vs_fall, col_wrap, at_origin, mismatch, err_d;
  assign o_Col_Count = col_q;
  assign o_Row_Count = row_q;
  assign o_Locked    = state_q == LOCKED;
  // Edge detection, free-running position and timing-mismatch detection for the new sample
  always_comb begin
    hs_rise   = i_HSync & ~hs_q;
    hs_fall   = ~i_HSync & hs_q;
    vs_rise   = i_VSync & ~vs_q;
    vs_fall   = ~i_VSync & vs_q;
    col_wrap  = col_q == 10'(TOTAL_COLS - 1);
    pc        = col_wrap ? 10'd0 : col_q + 10'd1;
    pr        = col_wrap ? ((row_q == 10'(TOTAL_ROWS - 1)) ? 10'd0 : row_q + 10'd1) : row_q;
    at_origin = pc == 10'd0 && pr == 10'd0;
    mismatch  = (hs_rise != (pc == 10'd0)) | (hs_fall != (pc == 10'(ACTIVE_COLS))) |
                (vs_fall != (pr == 10'(ACTIVE_ROWS) && pc == 10'd0)) | (vs_rise != at_origin);
    err_d     = state_q != SEARCH && mismatch;
    col_d     = vs_rise ? 10'd0 : pc;
    row_d     = vs_rise ? 10'd0 : pr;
  end
  // Lock FSM: any mismatch drops to SEARCH, clean frame starts accumulate towards lock
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (err_d) state_d = SEARCH;
    else if (vs_rise && state_q == SEARCH) begin
      state_d = ACQUIRE;
      cnt_d   = '0;
    end else if (vs_rise && state_q == ACQUIRE) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (int'(cnt_q) + 1 >= LOCK_FRAMES) ? LOCKED : ACQUIRE;
    end
  end
  // State, sample history, position and registered pulse outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= SEARCH;
      cnt_q         <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      o_Active      <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hs_q          <= i_HSync;
      vs_q          <= i_VSync;
      col_q         <= col_d;
      row_q         <= row_d;
      o_Active      <= i_HSync & i_VSync;
      o_Frame_Start <= vs_rise;
      o_Error       <= err_d;
    end
  end
`ifdef VGA_SYNC_DECODER_FRAME_COUNT_EN
  // Locked-frame counter: zero on the frame lock is gained, cleared whenever lock is absent
  always_ff @(posedge i_Clk) begin
    if (i_Reset) o_Frame_Count <= '0;
    else o_Frame_Count <= (state_d != LOCKED) ? 16'd0 : (vs_rise && state_q == LOCKED) ? o_Frame_Count + 16'd1 : o_Frame_Count;
  end
`endif
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800: clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525: lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640: clocks per line with HSync high.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480: lines per frame with VSync high.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2: clean frames required before lock.
REQ-006 SHALL have port i_Clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_HSync  input  1  high while source column < ACTIVE_COLS.
REQ-009 SHALL have port i_VSync  input  1  high while source row < ACTIVE_ROWS.
REQ-010 SHALL have port o_Col_Count  output  10  recovered column.
REQ-011 SHALL have port o_Row_Count  output  10  recovered row.
REQ-012 SHALL have port o_Active  output  1  registered i_HSync AND i_VSync.
REQ-013 SHALL have port o_Frame_Start  output  1  one-cycle pulse at recovered (0,0).
REQ-014 SHALL have port o_Locked  output  1  timing verified against parameters.
REQ-015 SHALL have port o_Error  output  1  one-cycle pulse on timing mismatch.

Function
REQ-016 SHALL register i_HSync/i_VSync once; all outputs are registered and refer to the sample taken on the previous edge (latency 1 clock).
REQ-017 SHALL detect rising/falling edges by comparing each new sample with the previous sample.
REQ-018 SHALL increment the column each clock, wrapping TOTAL_COLS-1 -> 0; on column wrap the row increments, wrapping TOTAL_ROWS-1 -> 0.
REQ-019 SHALL, on a VSync rising edge in any state, load column 0 and row 0 for that sample and pulse o_Frame_Start.
REQ-020 SHALL implement FSM states SEARCH, ACQUIRE, LOCKED.
REQ-021 SEARCH: no error checks; VSync rising edge -> ACQUIRE with clean-frame count 0.
REQ-022 ACQUIRE/LOCKED: mismatch = HSync rise with column != 0, expected HSync rise missing at column 0, HSync fall with column != ACTIVE_COLS, expected HSync fall missing, VSync fall with (row,col) != (ACTIVE_ROWS,0), expected VSync fall missing, or expected VSync rise missing at (0,0).
REQ-023 A mismatch SHALL pulse o_Error for one cycle and move to SEARCH; o_Locked deasserts in that same output cycle.
REQ-024 ACQUIRE: each clean VSync rising edge increments the count; when count reaches LOCK_FRAMES -> LOCKED, o_Locked high from that output cycle.
REQ-025 A VSync rise arriving before (TOTAL_ROWS-1,TOTAL_COLS-1) SHALL count as a mismatch (error plus SEARCH) and simultaneously restart counters at (0,0); the FSM SHALL remain in SEARCH, not re-enter ACQUIRE, until the next VSync rise.
REQ-026 Counters SHALL continue counting in every state; o_Active SHALL be independent of lock state.

Reset
REQ-027 i_Reset SHALL force state SEARCH, counters 0, clean-frame count 0, edge history 0, and o_Col_Count=0, o_Row_Count=0, o_Active=0, o_Frame_Start=0, o_Locked=0, o_Error=0 on the next edge.
REQ-028 Reset mid-frame SHALL drop lock with no o_Error pulse; reacquisition begins at the next VSync rising edge.

Configuration
REQ-029 With macro VGA_SYNC_DECODER_FRAME_COUNT_EN defined, port o_Frame_Count (output, 16) SHALL exist, increment on each o_Frame_Start while o_Locked, wrap 65535 -> 0, and clear on reset or loss of lock.
REQ-030 Without VGA_SYNC_DECODER_FRAME_COUNT_EN, o_Frame_Count and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset, then nominal 800x525 stream from frame start -> o_Frame_Start at (0,0) each frame; o_Locked rises at the third VSync rise (count reaches 2); o_Error never pulses.
REQ-032 Locked; one line has its HSync rise at column 5 -> o_Error single pulse, o_Locked low in the same cycle, relock after two further clean frames.
REQ-033 Locked; VSync held low for a whole frame -> o_Error at expected (0,0), state SEARCH.
REQ-034 Locked; i_Reset asserted at row 200 for 1 cycle -> all outputs 0 next cycle, no o_Error, relock after VSync rises.
REQ-035 Check o_Active equals registered i_HSync AND i_VSync; col 639 active, col 640 inactive.
REQ-036 With VGA_SYNC_DECODER_FRAME_COUNT_EN: o_Frame_Count counts 0,1,2 over locked frames, clears to 0 on the REQ-032 error.
